apb_slave_regfile: RTL and testbench

//  APB3 completer (slave) fronting a small word-addressed register file, with programmable wait states and PSLVERR.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slv_regfile.sv | 38 +++
 rtl/apb_slave_regfile.sv | 152 +++++++++++++++
 tb/tb_apb_slave_regfile.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } apb_state_e;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Register storage: one write port, async read port, entry 0 fixed to the ID value.
module apb_slv_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = 4,
  parameter logic [63:0] ID_VALUE   = 64'hA9B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [1:NUM_REGS-1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 1; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx == IDX_W'(i)) mem_q[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = DATA_WIDTH'(ID_VALUE);
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer over a small register file with programmable wait states and PSLVERR.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            WAIT_CYCLES = 2,
  parameter logic [63:0]            ID_VALUE    = 64'hA9B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned ALIGN = clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN) - 64'd1);
  localparam logic [7:0] CNT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic [ADDR_WIDTH-1:0] off, word_idx;
  logic [IDX_W-1:0]      dec_idx, rd_idx;
  logic                  dec_err;
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] rd_data;

  assign off      = PADDR - BASE_ADDR;
  assign word_idx = off >> ALIGN;
  assign dec_idx  = word_idx[IDX_W-1:0];
  assign dec_err  = (PADDR < BASE_ADDR) || ((off & ALIGN_MASK) != '0) ||
                    (word_idx >= ADDR_WIDTH'(NUM_REGS)) || (PWRITE && (dec_idx == '0));

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regs (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (reg_we),
    .widx    (idx_q),
    .wdata   (wdata_q),
    .ridx    (rd_idx),
    .rdata   (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    reg_we    = 1'b0;
    rd_idx    = idx_q;

    unique case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          write_d = PWRITE;
          err_d   = dec_err;
          idx_d   = dec_idx;
          wdata_d = PWDATA;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the response must already be registered for the first ACCESS cycle.
            rd_idx    = dec_idx;
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = dec_err ? APB_SLVERR : APB_OKAY;
            prdata_d  = (dec_err || PWRITE) ? '0 : rd_data;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d   = StResp;
          pready_d  = 1'b1;
          pslverr_d = err_q ? APB_SLVERR : APB_OKAY;
          prdata_d  = (err_q || write_q) ? '0 : rd_data;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        if (!PSEL || PENABLE) begin
          reg_we    = PSEL && write_q && !err_q;
          state_d   = StIdle;
          pready_d  = 1'b0;
          pslverr_d = APB_OKAY;
          prdata_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: a 2-wait-state instance (a) and a zero-wait instance (b) on separate buses.
module tb_apb_slave_regfile;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;

  logic        psel_a = 0, penable_a = 0, pwrite_a = 0;
  logic [31:0] paddr_a = '0, pwdata_a = '0, prdata_a;
  logic        pready_a, pslverr_a;
  logic        psel_b = 0, penable_b = 0, pwrite_b = 0;
  logic [31:0] paddr_b = '0, pwdata_b = '0, prdata_b;
  logic        pready_b, pslverr_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.WAIT_CYCLES(2)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a),
    .PADDR(paddr_a), .PWDATA(pwdata_a), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b),
    .PADDR(paddr_b), .PWDATA(pwdata_b), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b)
  );

  typedef struct {
    bit          sel;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pready_of(input bit sel);
    return sel ? pready_b : pready_a;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel) begin
      psel_b = s; penable_b = en; pwrite_b = wr; paddr_b = addr; pwdata_b = wd;
    end else begin
      psel_a = s; penable_a = en; pwrite_a = wr; paddr_a = addr; pwdata_a = wd;
    end
  endtask

  task automatic bus_idle(input bit sel);
    @(posedge PCLK); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Leaves the bus in ACCESS on return so the next call issues a back-to-back setup.
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int waits);
    bit done;
    @(posedge PCLK); #1;
    drive(sel, 1'b1, 1'b0, wr, addr, wd);
    @(negedge PCLK);
    check("setup_pready_low", {31'b0, pready_of(sel)}, 32'h0);
    @(posedge PCLK); #1;
    drive(sel, 1'b1, 1'b1, wr, addr, wd);
    waits = 0; rd = '0; err = 1'b0; done = 0;
    while (!done && waits < 20) begin
      @(negedge PCLK);
      if (pready_of(sel)) begin
        rd   = sel ? prdata_b : prdata_a;
        err  = sel ? pslverr_b : pslverr_a;
        done = 1;
      end else begin
        waits++;
      end
    end
  endtask

  vec_t        vecs[15];
  logic [31:0] rd;
  logic        err;
  int          waits;
  int          high_cnt;

  initial begin
    vecs[0]  = '{0, 0, 32'h00, 32'h0,         32'hA9B0_0001, 0, 2};
    vecs[1]  = '{0, 1, 32'h08, 32'hDEAD_BEEF, 32'h0,         0, 2};
    vecs[2]  = '{0, 0, 32'h08, 32'h0,         32'hDEAD_BEEF, 0, 2};
    vecs[3]  = '{0, 0, 32'h04, 32'h0,         32'h0,         0, 2};
    vecs[4]  = '{0, 0, 32'h0C, 32'h0,         32'h0,         0, 2};
    vecs[5]  = '{0, 1, 32'h00, 32'h1234,      32'h0,         1, 2};
    vecs[6]  = '{0, 1, 32'h40, 32'h1,         32'h0,         1, 2};
    vecs[7]  = '{0, 0, 32'h00, 32'h0,         32'hA9B0_0001, 0, 2};
    vecs[8]  = '{0, 0, 32'h40, 32'h0,         32'h0,         1, 2};
    vecs[9]  = '{0, 0, 32'h06, 32'h0,         32'h0,         1, 2};
    vecs[10] = '{0, 0, 32'h08, 32'h0,         32'hDEAD_BEEF, 0, 2};
    vecs[11] = '{0, 0, 32'h3C, 32'h0,         32'h0,         0, 2};
    vecs[12] = '{1, 1, 32'h0C, 32'hCAFE_F00D, 32'h0,         0, 0};
    vecs[13] = '{1, 0, 32'h0C, 32'h0,         32'hCAFE_F00D, 0, 0};
    vecs[14] = '{1, 0, 32'h04, 32'h0,         32'h0,         0, 0};

    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready_a", {31'b0, pready_a}, 32'h0);
    check("rst_pslverr_a", {31'b0, pslverr_a}, 32'h0);
    check("rst_prdata_a", prdata_a, 32'h0);
    check("rst_pready_b", {31'b0, pready_b}, 32'h0);
    PRESETn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, waits);
      check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_waits", i), waits, vecs[i].exp_waits);
      if (i == 11) bus_idle(0);
    end
    bus_idle(1);

    // Abort: PSEL drops after one WAIT cycle; nothing may complete or commit.
    @(posedge PCLK); #1;
    drive(0, 1'b1, 1'b0, 1'b1, 32'h04, 32'h55);
    @(posedge PCLK); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 32'h04, 32'h55);
    @(negedge PCLK);
    check("abort_wait_pready", {31'b0, pready_a}, 32'h0);
    bus_idle(0);
    high_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      if (pready_a) high_cnt++;
    end
    check("abort_pready_never", high_cnt, 0);
    xfer(0, 0, 32'h04, 32'h0, rd, err, waits);
    check("abort_reg1", rd, 32'h0);
    check("abort_read_err", {31'b0, err}, 32'h0);

    // Reset during the response phase must clear the outputs without waiting for an edge.
    xfer(0, 0, 32'h08, 32'h0, rd, err, waits);
    check("pre_rst_prdata", rd, 32'hDEAD_BEEF);
    #1 PRESETn = 1'b0;
    #1;
    check("rst_resp_pready", {31'b0, pready_a}, 32'h0);
    check("rst_resp_prdata", prdata_a, 32'h0);
    bus_idle(0);
    @(posedge PCLK); #1 PRESETn = 1'b1;

    // Reset mid-WAIT with a write in flight.
    @(posedge PCLK); #1;
    drive(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h77);
    @(posedge PCLK); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h77);
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    check("rst_wait_pready", {31'b0, pready_a}, 32'h0);
    check("rst_wait_pslverr", {31'b0, pslverr_a}, 32'h0);
    bus_idle(0);
    @(posedge PCLK); #1 PRESETn = 1'b1;

    xfer(0, 0, 32'h10, 32'h0, rd, err, waits);
    check("rst_discard_wr", rd, 32'h0);
    xfer(0, 0, 32'h08, 32'h0, rd, err, waits);
    check("rst_cleared_a", rd, 32'h0);
    bus_idle(0);
    xfer(1, 0, 32'h0C, 32'h0, rd, err, waits);
    check("rst_cleared_b", rd, 32'h0);
    bus_idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
